// File: rtl/i281_pkg.sv
// i281_pkg: shared widths and reader FSM encoding for the i281 data-memory blocks.
package i281_pkg;
  localparam int I281_DMEM_ADDR_W = 4;
  localparam int I281_DATA_W = 8;
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2,
    RD_DONE  = 2'd3
  } rd_state_e;
endpackage

// File: rtl/i281_skid_fifo.sv
// i281_skid_fifo: 2-entry output buffer holding {addr,data} words for the reader stream.
module i281_skid_fifo #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_wr;
  logic         r_rd;
  logic [1:0]   r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  assign o_valid = r_count != 2'd0;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/i281_dmem_reader.sv
// i281_dmem_reader: reads a block of data-memory words and streams them, address-tagged,
// over valid/ready with at most two words in flight or buffered.
module i281_dmem_reader
  import i281_pkg::*;
#(
  parameter int ADDR_W = I281_DMEM_ADDR_W,
  parameter int DATA_W = I281_DATA_W
) (
  input  logic              Board_Clock,
  input  logic              Reset_In,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_Addr,
  input  logic [ADDR_W-1:0] Count,
  output logic              Busy,
  output logic              Done,
  output logic              Mem_Rd_En,
  output logic [ADDR_W-1:0] Mem_Rd_Addr,
  input  logic [DATA_W-1:0] Mem_Rd_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic [ADDR_W-1:0] Out_Addr
);
  localparam int CW = ADDR_W + 1;
  rd_state_e                r_state;
  rd_state_e                w_next;
  logic [ADDR_W-1:0]        r_rd_ptr;
  logic [ADDR_W-1:0]        r_inflight_addr;
  logic                     r_inflight;
  logic [CW-1:0]            r_total;
  logic [CW-1:0]            r_issued;
  logic [CW-1:0]            r_accepted;
  logic                     w_rd_en;
  logic                     w_pop;
  logic                     w_last_issue;
  logic                     w_last_accept;
  logic [1:0]               w_count;
  logic [ADDR_W+DATA_W-1:0] w_head;
  assign w_pop = Out_Valid & Out_Ready;
  // A word leaving this cycle frees its slot for a new issue.
  assign w_rd_en = (r_state == RD_READ) &&
                   (({1'b0, w_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
  assign w_last_issue  = w_rd_en && (r_issued + CW'(1) == r_total);
  assign w_last_accept = w_pop && (r_accepted + CW'(1) == r_total);
  always_comb begin
    w_next = r_state;
    case (r_state)
      RD_IDLE:  w_next = Start ? RD_READ : RD_IDLE;
      RD_READ:  w_next = w_last_issue ? RD_DRAIN : RD_READ;
      RD_DRAIN: w_next = w_last_accept ? RD_DONE : RD_DRAIN;
      default:  w_next = RD_IDLE;
    endcase
  end
  always_ff @(posedge Board_Clock or negedge Reset_In) begin
    if (!Reset_In) begin
      r_state         <= RD_IDLE;
      r_rd_ptr        <= '0;
      r_inflight_addr <= '0;
      r_inflight      <= 1'b0;
      r_total         <= '0;
      r_issued        <= '0;
      r_accepted      <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_rd_en;
      if (w_rd_en) r_inflight_addr <= r_rd_ptr;
      if (r_state == RD_IDLE && Start) begin
        r_rd_ptr   <= Base_Addr;
        r_total    <= (Count == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, Count};
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (w_rd_en) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_issued <= r_issued + CW'(1);
        end
        if (w_pop) r_accepted <= r_accepted + CW'(1);
      end
    end
  end
  i281_skid_fifo #(.W(ADDR_W + DATA_W)) u_fifo (
    .clk     (Board_Clock),
    .rst_n   (Reset_In),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  ({r_inflight_addr, Mem_Rd_Data}),
    .o_valid (Out_Valid),
    .o_data  (w_head),
    .o_count (w_count)
  );
  assign Busy        = (r_state == RD_READ) || (r_state == RD_DRAIN);
  assign Done        = r_state == RD_DONE;
  assign Mem_Rd_En   = w_rd_en;
  assign Mem_Rd_Addr = r_rd_ptr;
  assign Out_Addr    = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign Out_Data    = w_head[DATA_W-1:0];
endmodule

// File: tb/tb_i281_dmem_reader.sv
// tb_i281_dmem_reader: directed scenarios against a bench-side memory preset to mem[i]=i*3.
// Cycle 0 is the cycle Start is high; results are recorded by cycle index from there.
module tb_i281_dmem_reader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] base = '0;
  logic [3:0] count = '0;
  logic [3:0] rd_addr;
  logic [3:0] out_addr;
  logic [7:0] rd_data = '0;
  logic [7:0] out_data;
  logic       busy, done, rd_en, out_valid;
  logic [7:0] mem [16];
  int cyc = 0, t0 = 0, n_checks = 0, n_pass = 0;
  int n_got, done_t, done_pulses, busy_gaps, stable_err, max_out;
  logic [3:0] got_addr [20];
  logic [7:0] got_data [20];
  int         hs_t [20];

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  i281_dmem_reader dut (
    .Board_Clock (clk),
    .Reset_In    (rst_n),
    .Start       (start),
    .Base_Addr   (base),
    .Count       (count),
    .Busy        (busy),
    .Done        (done),
    .Mem_Rd_En   (rd_en),
    .Mem_Rd_Addr (rd_addr),
    .Mem_Rd_Data (rd_data),
    .Out_Valid   (out_valid),
    .Out_Ready   (out_ready),
    .Out_Data    (out_data),
    .Out_Addr    (out_addr)
  );

  task automatic pulse_start(input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    start = 1'b1; base = b; count = c; out_ready = 1'b1; t0 = cyc;
  endtask

  // mode 0: Out_Ready held high; mode 1: Out_Ready follows 1,0,0,1 repeating.
  task automatic collect(input int mode, input int restart_at);
    logic pv, pr;
    logic [3:0] pa;
    logic [7:0] pd;
    int issued, acc, tail;
    pv = 1'b0; pr = 1'b1; pa = '0; pd = '0; issued = 0; acc = 0; tail = -1;
    n_got = 0; done_t = -1; done_pulses = 0; busy_gaps = 0; stable_err = 0; max_out = 0;
    for (int i = 1; i < 60 && tail != 0; i++) begin
      @(negedge clk);
      start = (i == restart_at);
      if (i == restart_at) base = base + 4'd7;
      out_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 1));
      #1;
      if (pv && !pr && (out_valid !== 1'b1 || out_addr !== pa || out_data !== pd)) stable_err++;
      if (out_valid && out_ready) begin
        if (n_got < 20) begin
          got_addr[n_got] = out_addr; got_data[n_got] = out_data; hs_t[n_got] = cyc - t0;
        end
        n_got++; acc++;
      end
      if (rd_en) issued++;
      if (issued - acc > max_out) max_out = issued - acc;
      if (done) begin
        done_pulses++;
        if (done_t < 0) begin done_t = cyc - t0; tail = 3; end
      end else if (done_t < 0 && !busy) busy_gaps++;
      if (tail > 0) tail--;
      pv = out_valid; pr = out_ready; pa = out_addr; pd = out_data;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if ({busy, done, rd_en, out_valid} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {busy, done, rd_en, out_valid}); else n_pass++;
    n_checks++; if ({rd_addr, out_addr, out_data} !== 16'h0) $display("FAIL reset_buses got %h exp 0000", {rd_addr, out_addr, out_data}); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    pulse_start(4'd0, 4'd8);
    collect(0, 0);
    n_checks++; if (n_got !== 8) $display("FAIL t1_words got %0d exp 8", n_got); else n_pass++;
    n_checks++; if (done_t !== 11) $display("FAIL t1_done_cycle got %0d exp 11", done_t); else n_pass++;
    n_checks++; if (done_pulses !== 1) $display("FAIL t1_done_pulses got %0d exp 1", done_pulses); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (got_addr[k] !== 4'(k) || got_data[k] !== 8'(3 * k) || hs_t[k] !== 3 + k)
        $display("FAIL t1_word%0d got a=%0d d=%0d t=%0d exp a=%0d d=%0d t=%0d", k, got_addr[k], got_data[k], hs_t[k], k, 3 * k, 3 + k);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [3:0] ea [4];
    ea[0] = 4'd14; ea[1] = 4'd15; ea[2] = 4'd0; ea[3] = 4'd1;
    pulse_start(4'd14, 4'd4);
    collect(0, 0);
    n_checks++; if (n_got !== 4) $display("FAIL t2_words got %0d exp 4", n_got); else n_pass++;
    n_checks++; if (done_t !== 7) $display("FAIL t2_done_cycle got %0d exp 7", done_t); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got_addr[k] !== ea[k] || got_data[k] !== 8'(3 * ea[k]))
        $display("FAIL t2_word%0d got a=%0d d=%0d exp a=%0d d=%0d", k, got_addr[k], got_data[k], ea[k], 3 * ea[k]);
      else n_pass++;
    end
  endtask

  task automatic test_count_zero();
    pulse_start(4'd0, 4'd0);
    collect(0, 0);
    n_checks++; if (n_got !== 16) $display("FAIL t3_words got %0d exp 16", n_got); else n_pass++;
    n_checks++; if (done_t !== 19) $display("FAIL t3_done_cycle got %0d exp 19", done_t); else n_pass++;
    n_checks++; if (busy_gaps !== 0) $display("FAIL t3_busy_gaps got %0d exp 0", busy_gaps); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (got_addr[k] !== 4'(k) || got_data[k] !== 8'(3 * k))
        $display("FAIL t3_word%0d got a=%0d d=%0d exp a=%0d d=%0d", k, got_addr[k], got_data[k], k, 3 * k);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    pulse_start(4'd3, 4'd5);
    collect(1, 0);
    n_checks++; if (n_got !== 5) $display("FAIL t4_words got %0d exp 5", n_got); else n_pass++;
    n_checks++; if (stable_err !== 0) $display("FAIL t4_stall_stable got %0d exp 0", stable_err); else n_pass++;
    n_checks++; if (max_out > 2) $display("FAIL t4_outstanding got %0d exp <=2", max_out); else n_pass++;
    n_checks++; if (done_pulses !== 1) $display("FAIL t4_done_pulses got %0d exp 1", done_pulses); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (got_addr[k] !== 4'(3 + k) || got_data[k] !== 8'(3 * (3 + k)))
        $display("FAIL t4_word%0d got a=%0d d=%0d exp a=%0d d=%0d", k, got_addr[k], got_data[k], 3 + k, 3 * (3 + k));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back_start();
    pulse_start(4'd2, 4'd6);
    collect(0, 3);
    n_checks++; if (n_got !== 6) $display("FAIL t5_words got %0d exp 6", n_got); else n_pass++;
    n_checks++; if (done_pulses !== 1) $display("FAIL t5_done_pulses got %0d exp 1", done_pulses); else n_pass++;
    n_checks++; if (done_t !== 9) $display("FAIL t5_done_cycle got %0d exp 9", done_t); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (got_addr[k] !== 4'(2 + k) || got_data[k] !== 8'(3 * (2 + k)))
        $display("FAIL t5_word%0d got a=%0d d=%0d exp a=%0d d=%0d", k, got_addr[k], got_data[k], 2 + k, 3 * (2 + k));
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int hs, bad;
    hs = 0; bad = 0;
    pulse_start(4'd0, 4'd8);
    for (int i = 1; i < 30 && hs < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (out_valid && out_ready) hs++;
    end
    n_checks++; if (hs !== 3) $display("FAIL t6_pre_words got %0d exp 3", hs); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, done, rd_en, out_valid} !== 4'b0) $display("FAIL t6_reset_flags got %b exp 0000", {busy, done, rd_en, out_valid}); else n_pass++;
    n_checks++; if ({rd_addr, out_addr, out_data} !== 16'h0) $display("FAIL t6_reset_buses got %h exp 0000", {rd_addr, out_addr, out_data}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (done || out_valid || busy || rd_en) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL t6_quiet_after_reset got %0d exp 0", bad); else n_pass++;
    pulse_start(4'd5, 4'd3);
    collect(0, 0);
    n_checks++; if (n_got !== 3) $display("FAIL t6_words got %0d exp 3", n_got); else n_pass++;
    n_checks++; if (done_t !== 6) $display("FAIL t6_done_cycle got %0d exp 6", done_t); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got_addr[k] !== 4'(5 + k) || got_data[k] !== 8'(3 * (5 + k)))
        $display("FAIL t6_word%0d got a=%0d d=%0d exp a=%0d d=%0d", k, got_addr[k], got_data[k], 5 + k, 3 * (5 + k));
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(3 * i);
    test_reset();
    test_basic();
    test_wrap();
    test_count_zero();
    test_backpressure();
    test_back_to_back_start();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
